// File: rtl/gci_node_irq_sender_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gci_node_irq_sender_pkg: shared GCI constants for the node IRQ path |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package gci_node_irq_sender_pkg;

  localparam int PRIO_W = 8;

  typedef logic [1:0] node_irq_stt_t;

  localparam node_irq_stt_t NODE_IRQ_STT_IDLE = 2'd0;
  localparam node_irq_stt_t NODE_IRQ_STT_REQ  = 2'd1;
  localparam node_irq_stt_t NODE_IRQ_STT_HELD = 2'd2;

  // Data registers without functional reset value are left unreset.
  localparam bit DATA_RESET_ENABLE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/gci_irq_event_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gci_irq_event_fifo: synchronous event FIFO with occupancy count     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gci_irq_event_fifo
  import gci_node_irq_sender_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     iCLOCK,
  input  logic                     inRESET,
  input  logic                     iPUSH,
  input  logic [WIDTH-1:0]         iPUSH_DATA,
  input  logic                     iPOP,
  output logic [WIDTH-1:0]         oHEAD,
  output logic                     oFULL,
  output logic                     oEMPTY,
  output logic [$clog2(DEPTH):0]   oCOUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (iPUSH) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (iPOP)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({iPUSH, iPOP})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    if (DATA_RESET_ENABLE) begin : g_mem_rst
      always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (iPUSH) begin
          mem_q[wr_ptr_q] <= iPUSH_DATA;
        end
      end
    end else begin : g_mem_norst
      always_ff @(posedge iCLOCK) begin
        if (iPUSH) mem_q[wr_ptr_q] <= iPUSH_DATA;
      end
    end
  endgenerate

  assign oHEAD  = mem_q[rd_ptr_q];
  assign oFULL  = (count_q == DEPTH[AW:0]);
  assign oEMPTY = (count_q == '0);
  assign oCOUNT = count_q;

endmodule
`default_nettype wire

// File: rtl/gci_node_irq_sender.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gci_node_irq_sender: node-side IRQ request / ACK / cause latch      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module gci_node_irq_sender
  import gci_node_irq_sender_pkg::*;
#(
  parameter int                FIFO_DEPTH = 4,
  parameter int                CODE_W     = 8,
  parameter logic [PRIO_W-1:0] PRIO_RESET = 8'h00
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  input  logic                          iENABLE,
  input  logic                          iEVENT_VALID,
  input  logic [CODE_W-1:0]             iEVENT_CODE,
  input  logic                          iPRIORITY_WR,
  input  logic [PRIO_W-1:0]             iPRIORITY_DATA,
  output logic [PRIO_W-1:0]             oNODEINFO_PRIORITY,
  input  logic                          iIRQ_BUSY,
  output logic                          oIRQ,
  input  logic                          iACK,
  output logic                          oCAUSE_VALID,
  output logic [CODE_W-1:0]             oCAUSE_CODE,
  input  logic                          iCAUSE_CLEAR,
  output logic [$clog2(FIFO_DEPTH):0]   oPENDING_COUNT,
  output logic                          oOVERFLOW,
  input  logic                          iOVF_CLEAR
);

  node_irq_stt_t       state_q;
  node_irq_stt_t       state_d;
  logic                cause_valid_q;
  logic [CODE_W-1:0]   cause_code_q;
  logic                ovf_q;
  logic [PRIO_W-1:0]   prio_q;

  logic                w_full;
  logic                w_empty;
  logic [CODE_W-1:0]   w_head;
  logic                w_ack_ok;
  logic                w_push;
  logic                w_drop;

  assign w_ack_ok = (state_q == NODE_IRQ_STT_REQ) && iACK && !iIRQ_BUSY;
  assign w_push   = iEVENT_VALID && iENABLE && (!w_full || w_ack_ok);
  assign w_drop   = iEVENT_VALID && iENABLE && w_full && !w_ack_ok;

  gci_irq_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iPUSH      (w_push),
    .iPUSH_DATA (iEVENT_CODE),
    .iPOP       (w_ack_ok),
    .oHEAD      (w_head),
    .oFULL      (w_full),
    .oEMPTY     (w_empty),
    .oCOUNT     (oPENDING_COUNT)
  );

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state_q <= NODE_IRQ_STT_IDLE;
    else          state_q <= state_d;
  end

  // An event arriving this cycle lets an idle node request on the next one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      NODE_IRQ_STT_IDLE:
        if ((!w_empty || w_push) && !cause_valid_q) state_d = NODE_IRQ_STT_REQ;
      NODE_IRQ_STT_REQ:
        if (w_ack_ok) state_d = NODE_IRQ_STT_HELD;
      NODE_IRQ_STT_HELD:
        if (iCAUSE_CLEAR) state_d = NODE_IRQ_STT_IDLE;
      default:
        state_d = NODE_IRQ_STT_IDLE;
    endcase
  end

  always_comb begin
    oIRQ = (state_q == NODE_IRQ_STT_REQ) && !iIRQ_BUSY;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cause_valid_q <= 1'b0;
      cause_code_q  <= '0;
      ovf_q         <= 1'b0;
      prio_q        <= PRIO_RESET;
    end else begin
      if (w_ack_ok) begin
        cause_valid_q <= 1'b1;
        cause_code_q  <= w_head;
      end else if (iCAUSE_CLEAR && (state_q == NODE_IRQ_STT_HELD)) begin
        cause_valid_q <= 1'b0;
      end
      if (w_drop)          ovf_q <= 1'b1;
      else if (iOVF_CLEAR) ovf_q <= 1'b0;
      if (iPRIORITY_WR) prio_q <= iPRIORITY_DATA;
    end
  end

  assign oCAUSE_VALID       = cause_valid_q;
  assign oCAUSE_CODE        = cause_code_q;
  assign oOVERFLOW          = ovf_q;
  assign oNODEINFO_PRIORITY = prio_q;

endmodule
`default_nettype wire
